noobs_dmem_ctrl: RTL and testbench



---
 rtl/noobs_dmem_ctrl_if.sv | 14 +
 rtl/noobs_dmem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_noobs_dmem_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/noobs_dmem_ctrl_if.sv
// CPU data-memory bus: noobs_cpu drives the request side, noobs_dmem_ctrl answers.
interface noobs_dmem_ctrl_if;
  logic [11:0] m_addr;
  logic [7:0]  m_wr_data;
  logic [7:0]  m_rd_data;
  logic        m_rd;
  logic        m_wr;
  logic        m_en;

  modport master (output m_addr, output m_wr_data, output m_rd, output m_wr,
                  output m_en, input m_rd_data);
  modport slave  (input m_addr, input m_wr_data, input m_rd, input m_wr,
                  input m_en, output m_rd_data);
endinterface

// File: rtl/noobs_dmem_ctrl.sv
// Data-memory responder: byte RAM plus a peripheral window holding a UART
// transmitter, its status/divisor registers and a free-running 8-bit timer.
module noobs_dmem_ctrl #(
  parameter int unsigned RAM_DEPTH   = 2048,
  parameter logic [11:0] MMIO_BASE   = 12'hFF0,
  parameter logic [7:0]  DEFAULT_DIV = 8'd15
) (
  input  logic                    clk,
  input  logic                    reset_,
  noobs_dmem_ctrl_if.slave        bus,
  output logic                    uart_tx,
  output logic                    access_err
);
  localparam int unsigned AW      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [12:0] RAM_END = 13'(RAM_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic [7:0]  ram [RAM_DEPTH];
  logic [7:0]  rd_data_r, uart_data_r, div_r, div_frame_r, timer_r;
  logic [7:0]  shift_r, cnt_r;
  logic [2:0]  idx_r;
  logic        overrun_r, tx_r, err_r;
  uart_state_t state_r;

  uart_state_t state_nx;
  logic [7:0]  shift_nx, cnt_nx, div_frame_nx, rd_val_s;
  logic [2:0]  idx_nx;
  logic        tx_nx, bit_end_s;

  logic          rd_req_s, wr_req_s, conflict_s;
  logic          in_ram_s, in_mmio_s, in_hole_s, busy_s;
  logic          wr_ram_s, wr_data_s, wr_stat_s, wr_div_s, wr_tmr_s, start_s;
  logic [3:0]    mmio_off_s;
  logic [AW-1:0] ram_idx_s;

  assign rd_req_s   = bus.m_en & bus.m_rd & ~bus.m_wr;
  assign wr_req_s   = bus.m_en & bus.m_wr & ~bus.m_rd;
  assign conflict_s = bus.m_en & bus.m_rd & bus.m_wr;

  assign in_ram_s   = ({1'b0, bus.m_addr} < RAM_END);
  assign in_mmio_s  = (bus.m_addr >= MMIO_BASE);
  assign in_hole_s  = ~in_ram_s & ~in_mmio_s;
  // Window is 16 bytes, so the low nibble difference is the register offset
  assign mmio_off_s = bus.m_addr[3:0] - MMIO_BASE[3:0];
  assign ram_idx_s  = bus.m_addr[AW-1:0];

  assign busy_s    = (state_r != IDLE);
  assign wr_ram_s  = wr_req_s & in_ram_s;
  assign wr_data_s = wr_req_s & in_mmio_s & (mmio_off_s == 4'd0);
  assign wr_stat_s = wr_req_s & in_mmio_s & (mmio_off_s == 4'd1);
  assign wr_div_s  = wr_req_s & in_mmio_s & (mmio_off_s == 4'd2);
  assign wr_tmr_s  = wr_req_s & in_mmio_s & (mmio_off_s == 4'd3);
  assign start_s   = wr_data_s & ~busy_s;

  assign bus.m_rd_data = rd_data_r;
  assign uart_tx       = tx_r;
  assign access_err    = err_r;

  // Read data mux over RAM and the peripheral registers
  always_comb begin
    rd_val_s = 8'h00;
    if (in_ram_s) begin
      rd_val_s = ram[ram_idx_s];
    end else if (in_mmio_s) begin
      case (mmio_off_s)
        4'd0:    rd_val_s = uart_data_r;
        4'd1:    rd_val_s = {6'b000000, overrun_r, busy_s};
        4'd2:    rd_val_s = div_r;
        4'd3:    rd_val_s = timer_r;
        default: rd_val_s = 8'h00;
      endcase
    end else begin
      rd_val_s = 8'h00;
    end
  end

  // UART next-state logic; uart_tx is computed for the state being entered
  always_comb begin
    state_nx     = state_r;
    cnt_nx       = cnt_r;
    idx_nx       = idx_r;
    shift_nx     = shift_r;
    div_frame_nx = div_frame_r;
    tx_nx        = tx_r;
    bit_end_s    = (cnt_r == div_frame_r);
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nx     = START;
          cnt_nx       = 8'd0;
          idx_nx       = 3'd0;
          shift_nx     = bus.m_wr_data;
          div_frame_nx = div_r;
          tx_nx        = 1'b0;
        end else begin
          tx_nx = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_nx = DATA;
          cnt_nx   = 8'd0;
          tx_nx    = shift_r[0];
        end else begin
          cnt_nx = cnt_r + 8'd1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_nx = 8'd0;
          if (idx_r == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            idx_nx   = idx_r + 3'd1;
            shift_nx = {1'b0, shift_r[7:1]};
            tx_nx    = shift_r[1];
          end
        end else begin
          cnt_nx = cnt_r + 8'd1;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
          tx_nx    = 1'b1;
        end else begin
          cnt_nx = cnt_r + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end

  // UART state register; reset forces the line idle immediately
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      idx_r       <= 3'd0;
      shift_r     <= 8'h00;
      div_frame_r <= DEFAULT_DIV;
      tx_r        <= 1'b1;
    end else begin
      state_r     <= state_nx;
      cnt_r       <= cnt_nx;
      idx_r       <= idx_nx;
      shift_r     <= shift_nx;
      div_frame_r <= div_frame_nx;
      tx_r        <= tx_nx;
    end
  end

  // Bus response, peripheral registers and timer
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rd_data_r   <= 8'h00;
      err_r       <= 1'b0;
      uart_data_r <= 8'h00;
      div_r       <= DEFAULT_DIV;
      overrun_r   <= 1'b0;
      timer_r     <= 8'h00;
    end else begin
      err_r <= conflict_s | ((rd_req_s | wr_req_s) & in_hole_s);
      if (rd_req_s) rd_data_r <= rd_val_s;
      if (start_s) uart_data_r <= bus.m_wr_data;
      if (wr_div_s) div_r <= bus.m_wr_data;
      if (wr_stat_s) begin
        overrun_r <= 1'b0;
      end else if (wr_data_s & busy_s) begin
        overrun_r <= 1'b1;
      end
      if (wr_tmr_s) begin
        timer_r <= bus.m_wr_data;
      end else begin
        timer_r <= timer_r + 8'd1;
      end
    end
  end

  // RAM array carries no reset so it can map onto block memory
  always_ff @(posedge clk) begin
    if (wr_ram_s) ram[ram_idx_s] <= bus.m_wr_data;
  end
endmodule

// File: tb/tb_noobs_dmem_ctrl.sv
// Randomized bench for noobs_dmem_ctrl against a cycle-count based reference model.
module tb_noobs_dmem_ctrl;
  logic clk = 1'b0;
  logic reset_;
  logic uart_tx, access_err;

  noobs_dmem_ctrl_if bus();

  noobs_dmem_ctrl dut (
    .clk        (clk),
    .reset_     (reset_),
    .bus        (bus),
    .uart_tx    (uart_tx),
    .access_err (access_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: frames and timer are described by the edge they started at
  logic [7:0] ram_m [0:2047];
  logic [7:0] exp_rd, div_m, uart_last_m, tmr_base, frame_byte;
  logic       exp_err;
  bit         ovr_m, frame_valid;
  int         frame_t, frame_d, tmr_t;
  bit         levels [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at edge %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit busy_at(int k);
    return frame_valid && ((k - frame_t) < 10 * (frame_d + 1));
  endfunction

  function automatic logic tx_at(int k);
    int j;
    if (!busy_at(k)) return 1'b1;
    j = (k - frame_t) / (frame_d + 1);
    if (j == 0) return 1'b0;
    if (j <= 8) return frame_byte[j-1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] timer_at(int k);
    return 8'(int'(tmr_base) + (k - tmr_t));
  endfunction

  function automatic logic [11:0] pool_addr(int r);
    return (r < 16) ? 12'(16 + r) : 12'(2032 + (r - 16));
  endfunction

  task automatic model_reset();
    frame_valid = 1'b0;
    ovr_m       = 1'b0;
    div_m       = 8'd15;
    uart_last_m = 8'h00;
    tmr_base    = 8'h00;
    tmr_t       = cyc;
    exp_rd      = 8'h00;
    exp_err     = 1'b0;
  endtask

  task automatic model_edge();
    bit rd, wr, conf, hole;
    int a, e;
    logic [7:0] d;
    cyc++;
    e    = cyc;
    rd   = bus.m_en && bus.m_rd && !bus.m_wr;
    wr   = bus.m_en && bus.m_wr && !bus.m_rd;
    conf = bus.m_en && bus.m_rd && bus.m_wr;
    a    = int'(bus.m_addr);
    d    = bus.m_wr_data;
    hole = (a >= 2048) && (a < 'hFF0);
    exp_err = conf || ((rd || wr) && hole);
    if (rd) begin
      if (a < 2048)       exp_rd = ram_m[a];
      else if (a == 'hFF0) exp_rd = uart_last_m;
      else if (a == 'hFF1) exp_rd = {6'b000000, ovr_m, busy_at(e - 1)};
      else if (a == 'hFF2) exp_rd = div_m;
      else if (a == 'hFF3) exp_rd = timer_at(e - 1);
      else                 exp_rd = 8'h00;
    end
    if (wr) begin
      if (a < 2048) begin
        ram_m[a] = d;
      end else if (a == 'hFF0) begin
        if (!busy_at(e - 1)) begin
          frame_valid = 1'b1;
          frame_t     = e;
          frame_d     = int'(div_m);
          frame_byte  = d;
          uart_last_m = d;
        end else begin
          ovr_m = 1'b1;
        end
      end else if (a == 'hFF1) begin
        ovr_m = 1'b0;
      end else if (a == 'hFF2) begin
        div_m = d;
      end else if (a == 'hFF3) begin
        tmr_base = d;
        tmr_t    = e;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("rd_data", bus.m_rd_data, exp_rd);
    check_val("access_err", {7'd0, access_err}, {7'd0, exp_err});
    check_val("uart_tx", {7'd0, uart_tx}, {7'd0, tx_at(cyc)});
  endtask

  task automatic drive(input logic en, input logic rd, input logic wr,
                       input logic [11:0] a, input logic [7:0] d);
    bus.m_en      = en;
    bus.m_rd      = rd;
    bus.m_wr      = wr;
    bus.m_addr    = a;
    bus.m_wr_data = d;
  endtask

  task automatic op(input logic en, input logic rd, input logic wr,
                    input logic [11:0] a, input logic [7:0] d);
    drive(en, rd, wr, a, d);
    step();
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    reset_ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rd_data", bus.m_rd_data, 8'h00);
    check_val("rst_err", {7'd0, access_err}, 8'h00);
    check_val("rst_tx", {7'd0, uart_tx}, 8'h01);
    model_reset();
    reset_ = 1'b1;

    for (int r = 0; r < 32; r++) op(1'b1, 1'b0, 1'b1, pool_addr(r), 8'($urandom));

    op(1'b1, 1'b0, 1'b1, 12'h123, 8'h5A);
    op(1'b1, 1'b1, 1'b0, 12'h123, 8'h00);
    check_val("ram_rt_123", bus.m_rd_data, 8'h5A);
    op(1'b1, 1'b0, 1'b1, 12'h7FF, 8'hC3);
    op(1'b1, 1'b1, 1'b0, 12'h7FF, 8'h00);
    check_val("ram_rt_7ff", bus.m_rd_data, 8'hC3);

    op(1'b1, 1'b1, 1'b0, 12'h900, 8'h00);
    check_val("hole_rd", bus.m_rd_data, 8'h00);
    check_val("hole_err", {7'd0, access_err}, 8'h01);
    op(1'b1, 1'b0, 1'b1, 12'h010, 8'h33);
    op(1'b1, 1'b1, 1'b0, 12'h123, 8'h00);
    op(1'b1, 1'b1, 1'b1, 12'h010, 8'hEE);
    check_val("conf_err", {7'd0, access_err}, 8'h01);
    check_val("conf_hold", bus.m_rd_data, 8'h5A);
    step();
    check_val("conf_err_1cyc", {7'd0, access_err}, 8'h00);
    op(1'b1, 1'b1, 1'b0, 12'h010, 8'h00);
    check_val("conf_ram", bus.m_rd_data, 8'h33);

    op(1'b1, 1'b0, 1'b1, 12'hFF2, 8'h03);
    op(1'b1, 1'b0, 1'b1, 12'hFF0, 8'hA5);
    check_val("frame_level", {7'd0, uart_tx}, 8'h00);
    for (int j = 1; j < 40; j++) begin
      if (j == 10) drive(1'b1, 1'b1, 1'b0, 12'hFF1, 8'h00);
      step();
      drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      check_val("frame_level", {7'd0, uart_tx}, {7'd0, levels[j/4]});
      if (j == 10) check_val("status_busy", bus.m_rd_data, 8'h01);
    end
    step();
    op(1'b1, 1'b1, 1'b0, 12'hFF1, 8'h00);
    check_val("status_idle", bus.m_rd_data, 8'h00);

    op(1'b1, 1'b0, 1'b1, 12'hFF0, 8'h3C);
    op(1'b1, 1'b0, 1'b1, 12'hFF0, 8'hFF);
    op(1'b1, 1'b1, 1'b0, 12'hFF1, 8'h00);
    check_val("status_ovr", bus.m_rd_data, 8'h03);
    op(1'b1, 1'b0, 1'b1, 12'hFF1, 8'h00);
    op(1'b1, 1'b1, 1'b0, 12'hFF1, 8'h00);
    check_val("status_clr", bus.m_rd_data, 8'h01);
    repeat (40) step();

    op(1'b1, 1'b0, 1'b1, 12'hFF3, 8'hFE);
    drive(1'b1, 1'b1, 1'b0, 12'hFF3, 8'h00);
    step();
    check_val("tmr_fe", bus.m_rd_data, 8'hFE);
    step();
    check_val("tmr_ff", bus.m_rd_data, 8'hFF);
    step();
    check_val("tmr_wrap", bus.m_rd_data, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      int k;
      k = $urandom_range(0, 11);
      case (k)
        0, 1: drive(1'b1, 1'b1, 1'b0, pool_addr($urandom_range(0, 31)), 8'h00);
        2:    drive(1'b1, 1'b0, 1'b1, pool_addr($urandom_range(0, 31)), 8'($urandom));
        3: begin
          if ($urandom_range(0, 1) == 0)
            drive(1'b1, 1'b1, 1'b0, 12'($urandom_range(2048, 4079)), 8'h00);
          else
            drive(1'b1, 1'b0, 1'b1, 12'($urandom_range(2048, 4079)), 8'($urandom));
        end
        4:    drive(1'b1, 1'b1, 1'b1, 12'($urandom), 8'($urandom));
        5:    drive(1'b1, 1'b1, 1'b0, 12'(4080 + $urandom_range(0, 15)), 8'h00);
        6:    drive(1'b1, 1'b0, 1'b1, 12'hFF0, 8'($urandom));
        7:    drive(1'b1, 1'b0, 1'b1, 12'hFF2, 8'($urandom_range(0, 3)));
        8:    drive(1'b1, 1'b0, 1'b1, 12'(4081 + 2 * $urandom_range(0, 1)), 8'($urandom));
        9:    drive(1'b0, 1'($urandom), 1'($urandom), 12'($urandom), 8'($urandom));
        default: drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      endcase
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);

    repeat (45) step();
    op(1'b1, 1'b0, 1'b1, 12'hFF2, 8'h03);
    op(1'b1, 1'b0, 1'b1, 12'hFF0, 8'h00);
    repeat (8) step();
    reset_ = 1'b0;
    #1;
    check_val("rst_async_tx", {7'd0, uart_tx}, 8'h01);
    check_val("rst_async_rd", bus.m_rd_data, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_ = 1'b1;
    op(1'b1, 1'b1, 1'b0, 12'hFF3, 8'h00);
    check_val("rst_timer", bus.m_rd_data, 8'h00);
    op(1'b1, 1'b1, 1'b0, 12'hFF1, 8'h00);
    check_val("rst_status", bus.m_rd_data, 8'h00);
    op(1'b1, 1'b1, 1'b0, 12'hFF2, 8'h00);
    check_val("rst_div", bus.m_rd_data, 8'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
